// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, IF/ID delivery and pipeline control.
// The master side belongs to pc_fetch_unit; the slave side is memory plus downstream.
interface pc_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_addr_o;
    logic              valid_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, inst_o, pc_addr_o, valid_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, inst_o, pc_addr_o, valid_o
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction-fetch stage feeding IF/ID: one fetch outstanding,
// a one-entry hold buffer for stalls, and squash/redirect on jumps and branches.
module pc_fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [DATA_W-1:0]  NOP_INST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    pc_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_req;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc_addr;
    logic              r_valid;
    logic [DATA_W-1:0] r_buf_inst;
    logic [ADDR_W-1:0] r_buf_pc;

    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_seq_addr;

    assign w_target   = bus.redirect_pc_i & ~ADDR_W'(3);
    assign w_seq_addr = r_req_addr + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_req      <= 1'b0;
            r_inst     <= NOP_INST;
            r_pc_addr  <= '0;
            r_valid    <= 1'b0;
            r_buf_inst <= '0;
            r_buf_pc   <= '0;
        end else begin
            // Bubble by default when downstream can take it, and always on redirect;
            // deliveries below override this.
            if (!bus.stall_i || bus.redirect_i) begin
                r_inst    <= NOP_INST;
                r_pc_addr <= '0;
                r_valid   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_req      <= 1'b1;
                    r_req_addr <= bus.redirect_i ? w_target : r_pc;
                    if (bus.redirect_i) begin
                        r_pc <= w_target;
                    end
                end

                S_REQ: begin
                    if (bus.redirect_i) begin
                        r_pc <= w_target;
                        if (bus.imem_ack_i) begin
                            r_req_addr <= w_target;
                        end else begin
                            // Request stays up with its old address until the squashed ack.
                            r_state <= S_KILL;
                        end
                    end else if (bus.imem_ack_i) begin
                        r_pc <= w_seq_addr;
                        if (!bus.stall_i) begin
                            r_inst     <= bus.imem_rdata_i;
                            r_pc_addr  <= r_req_addr;
                            r_valid    <= 1'b1;
                            r_req_addr <= w_seq_addr;
                        end else begin
                            r_buf_inst <= bus.imem_rdata_i;
                            r_buf_pc   <= r_req_addr;
                            r_req      <= 1'b0;
                            r_state    <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (bus.redirect_i) begin
                        r_pc       <= w_target;
                        r_req_addr <= w_target;
                        r_req      <= 1'b1;
                        r_state    <= S_REQ;
                    end else if (!bus.stall_i) begin
                        r_inst     <= r_buf_inst;
                        r_pc_addr  <= r_buf_pc;
                        r_valid    <= 1'b1;
                        r_req_addr <= r_pc;
                        r_req      <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end

                S_KILL: begin
                    if (bus.redirect_i) begin
                        r_pc <= w_target;
                    end
                    if (bus.imem_ack_i) begin
                        r_req_addr <= bus.redirect_i ? w_target : r_pc;
                        r_state    <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_o  = r_req;
    assign bus.imem_addr_o = r_req_addr;
    assign bus.inst_o      = r_inst;
    assign bus.pc_addr_o   = r_pc_addr;
    assign bus.valid_o     = r_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a wait-state memory model with hand-sequenced
// stalls, redirects and resets, checking fetch addresses and IF/ID outputs each cycle.
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    int   wait_states = 0;
    int   wcnt        = 0;
    logic stray_ack   = 1'b0;

    pc_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    pc_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    // Memory: acks after wait_states cycles of a held request
    assign bus.imem_ack_i   = stray_ack | (bus.imem_req_o && (wcnt == wait_states));
    assign bus.imem_rdata_i = word(bus.imem_addr_o);

    always @(posedge clk) begin
        if (bus.imem_req_o && !bus.imem_ack_i) wcnt <= wcnt + 1;
        else                                   wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"},  32'(bus.imem_req_o), 32'(req));
        chk({tag, ".addr"}, bus.imem_addr_o, addr);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst);
        chk({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
        chk({tag, ".pc"},    bus.pc_addr_o, pc);
        chk({tag, ".inst"},  bus.inst_o, inst);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = tgt;
    endtask

    initial begin
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;

        tick();
        tick();
        chk_fetch("reset", 1'b0, 32'h0);
        chk_out("reset", 1'b0, 32'h0, 32'h0);

        // Zero-wait streaming from RESET_PC
        rst = 1'b0;
        tick();
        chk_fetch("zw0", 1'b1, 32'h0);
        chk_out("zw0", 1'b0, 32'h0, 32'h0);
        tick();
        chk_fetch("zw1", 1'b1, 32'h4);
        chk_out("zw1", 1'b1, 32'h0, word(32'h0));
        tick();
        chk_fetch("zw2", 1'b1, 32'h8);
        chk_out("zw2", 1'b1, 32'h4, word(32'h4));
        tick();
        chk_fetch("zw3", 1'b1, 32'hC);
        chk_out("zw3", 1'b1, 32'h8, word(32'h8));

        // Redirect to 0x10 on an ack, then 2 wait states there
        redirect_to(32'h10);
        tick();
        bus.redirect_i = 1'b0;
        wait_states    = 2;
        chk_fetch("ws0", 1'b1, 32'h10);
        chk_out("ws0", 1'b0, 32'h0, 32'h0);
        tick();
        chk_fetch("ws1", 1'b1, 32'h10);
        chk_out("ws1", 1'b0, 32'h0, 32'h0);
        tick();
        chk_fetch("ws2", 1'b1, 32'h10);
        chk_out("ws2", 1'b0, 32'h0, 32'h0);
        tick();
        chk_fetch("ws3", 1'b1, 32'h14);
        chk_out("ws3", 1'b1, 32'h10, word(32'h10));

        // Stall in the ack cycle of 0x20 while 0x1C sits on the outputs
        wait_states = 0;
        redirect_to(32'h1C);
        tick();
        bus.redirect_i = 1'b0;
        chk_fetch("st_r", 1'b1, 32'h1C);
        tick();
        chk_fetch("st_d", 1'b1, 32'h20);
        chk_out("st_d", 1'b1, 32'h1C, word(32'h1C));
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold.req", 32'(bus.imem_req_o), 32'h0);
            chk_out("st_hold", 1'b1, 32'h1C, word(32'h1C));
        end
        bus.stall_i = 1'b0;
        tick();
        chk_fetch("st_rel", 1'b1, 32'h24);
        chk_out("st_rel", 1'b1, 32'h20, word(32'h20));

        // Redirect to 0x103 while 0x40 is outstanding: squash through KILL
        redirect_to(32'h40);
        tick();
        wait_states = 2;
        redirect_to(32'h103);
        chk_fetch("kl_a", 1'b1, 32'h40);
        tick();
        bus.redirect_i = 1'b0;
        chk_fetch("kl_b", 1'b1, 32'h40);
        chk_out("kl_b", 1'b0, 32'h0, 32'h0);
        tick();
        chk_fetch("kl_c", 1'b1, 32'h40);
        chk_out("kl_c", 1'b0, 32'h0, 32'h0);
        tick();
        chk_fetch("kl_d", 1'b1, 32'h100);
        chk_out("kl_d", 1'b0, 32'h0, 32'h0);
        wait_states = 0;
        tick();
        chk_out("kl_e", 1'b1, 32'h100, word(32'h100));

        // Redirect to 0x200 coincident with the ack of 0x80
        redirect_to(32'h80);
        tick();
        redirect_to(32'h200);
        tick();
        bus.redirect_i = 1'b0;
        chk_fetch("ra_a", 1'b1, 32'h200);
        chk_out("ra_a", 1'b0, 32'h0, 32'h0);
        tick();
        chk_out("ra_b", 1'b1, 32'h200, word(32'h200));

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        tick();
        bus.redirect_i = 1'b0;
        chk_fetch("wr_a", 1'b1, 32'hFFFF_FFFC);
        tick();
        chk_fetch("wr_b", 1'b1, 32'h0);
        chk_out("wr_b", 1'b1, 32'hFFFF_FFFC, word(32'hFFFF_FFFC));

        // Reset while 0x50 is outstanding, with a stray ack across reset and IDLE
        redirect_to(32'h50);
        tick();
        bus.redirect_i = 1'b0;
        wait_states    = 3;
        tick();
        chk_fetch("rs_pre", 1'b1, 32'h50);
        rst       = 1'b1;
        stray_ack = 1'b1;
        #1;
        chk_fetch("rs_async", 1'b0, 32'h0);
        chk_out("rs_async", 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk_fetch("rs_post", 1'b1, 32'h0);
        chk_out("rs_post", 1'b0, 32'h0, 32'h0);
        stray_ack   = 1'b0;
        wait_states = 0;
        tick();
        chk_out("rs_first", 1'b1, 32'h0, word(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Delivers {inst_o, pc_addr_o, valid_o} to IF/ID.
- Honours pipeline stalls with a one-entry hold buffer, and squashes/redirects on jump or branch.

Parameters:
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, instruction driven on bubbles.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  full pipeline stall; downstream cannot accept.
- redirect_i  in  1  one-cycle pulse: jump/branch taken.
- redirect_pc_i  in  ADDR_W  redirect target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_W  fetch address, word aligned.
- imem_ack_i  in  1  read data valid this cycle.
- imem_rdata_i  in  DATA_W  instruction read data.
- inst_o  out  DATA_W  fetched instruction to IF/ID.
- pc_addr_o  out  ADDR_W  address of inst_o.
- valid_o  out  1  inst_o is a real instruction, not a bubble.

Behaviour:

Reset (rst high, asynchronous):
- state=IDLE, pc=RESET_PC, req_addr=0, imem_req_o=0.
- inst_o=NOP_INST, pc_addr_o=0, valid_o=0, hold buffer cleared.
- Reset mid-request: the outstanding fetch is abandoned. Memory must tolerate a dropped request; any ack seen in IDLE is ignored.

Priority: rst > redirect_i > stall_i.

General rules:
- Outputs register only. With stall_i=1, inst_o, pc_addr_o and valid_o hold their values.
- With stall_i=0 and no instruction delivered this cycle, outputs load a bubble: NOP_INST, pc_addr_o=0, valid_o=0.
- imem_addr_o comes from the req_addr register. It stays stable, and imem_req_o stays high, from first assertion until the ack cycle. A request is never withdrawn except by rst.
- Ack is allowed in the same cycle req is first asserted (zero-wait memory).
- PC arithmetic: pc+4 modulo 2^ADDR_W; 'hFFFF_FFFC+4 wraps to 0.
- Redirect target is forced word aligned (low 2 bits cleared).

State IDLE (req=0):
- Next cycle goes to REQ, req_addr=pc.
- Redirect in IDLE: pc=target, go to REQ with req_addr=target.

State REQ (req=1):
- Ack, no redirect, stall_i=0: outputs <= {rdata, req_addr, 1}; pc,req_addr <= req_addr+4; stay REQ. Back-to-back streaming gives 1 instruction/cycle with zero-wait memory.
- Ack, no redirect, stall_i=1: buffer <= {rdata, req_addr}; pc <= req_addr+4; go to HOLD.
- No ack: stay REQ. A stall does not drop the request.
- Redirect, ack same cycle: discard rdata; pc,req_addr <= target; stay REQ.
- Redirect, no ack: pc <= target; go to KILL.
- Every redirect also loads a bubble onto the outputs, regardless of stall_i.

State HOLD (req=0):
- stall_i=0: outputs <= {buffer, valid=1}; req_addr <= pc; go to REQ.
- Redirect: discard buffer; pc,req_addr <= target; outputs bubble; go to REQ.

State KILL (req=1, req_addr unchanged):
- Waits for the ack of the squashed fetch and discards it.
- On ack: req_addr <= pc (the redirect target); go to REQ.
- A second redirect during KILL overwrites pc; the last target wins.

Invariant: at most one fetch outstanding; no instruction is delivered twice or skipped.

Test Plan:
- Reset release, zero-wait memory (ack = req): imem_addr_o sequence 0,4,8,C. valid_o first high with pc_addr_o=0, inst_o equal to word@0, one cycle after the ack of addr 0.
- 2-wait-state memory: req held 3 cycles at addr 0x10 with stable address. Outputs show bubbles (valid_o=0) until the ack, then {word@0x10, 0x10, 1}.
- stall_i raised in the ack cycle of 0x20: outputs frozen and state HOLD with req low. Stall held 3 cycles. On release, outputs become {word@0x20, 0x20, 1} and the next request is 0x24.
- redirect_i to 0x103 while fetch of 0x40 is outstanding (ack 2 cycles later): the 0x40 data never reaches the outputs. Next request is 0x100, valid_o=0 until that delivery.
- Redirect to 0x200 coincident with the ack of 0x80: 0x80 is discarded and the next imem_addr_o is 0x200 with no idle cycle. Repeat with PC at 0xFFFF_FFFC: the next fetch wraps to 0x0.
- Assert rst mid-wait (request to 0x50 outstanding): imem_req_o=0 and outputs zero/bubble immediately. A stray ack during reset/IDLE is ignored. The first post-reset request is RESET_PC.
